// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the issue controller: divider FSM encodings,
// register-file size and divider counter width.
package issue_ctrl_pkg;

  // Divider sequencer states
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Architectural GPR count
  localparam int REG_NUM = 32;

  // Width of the divider latency counter (latency up to 63)
  localparam int DIV_CNT_W = 6;

endpackage : issue_ctrl_pkg

// File: rtl/issue_ctrl_div_seq_fsm.sv
// Fixed-latency divider sequencer: IDLE -> BUSY (DIV_LAT cycles) -> DONE
// (one cycle) -> IDLE. A flush abandons the division without a done pulse.
module div_seq_fsm
  import issue_ctrl_pkg::*;
#(
  parameter int DIV_LAT = 33
) (
  input  logic clk,
  input  logic reset,     // asynchronous, active-low
  input  logic i_start,   // a div issues this cycle
  input  logic i_flush,   // pipeline flush
  output logic o_busy,
  output logic o_done,
  output logic o_idle
);

  // Counter reload: BUSY lasts cnt+1 cycles, so load latency minus one
  localparam logic [DIV_CNT_W-1:0] LP_CNT_INIT = DIV_CNT_W'(DIV_LAT - 1);

  div_state_e            r_state;
  div_state_e            w_state_next;
  logic [DIV_CNT_W-1:0]  r_cnt;
  logic [DIV_CNT_W-1:0]  w_cnt_next;

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state and counter logic; flush overrides everything
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (i_flush) begin
      w_state_next = DIV_IDLE;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (i_start) begin
            w_state_next = DIV_BUSY;
            w_cnt_next   = LP_CNT_INIT;
          end
        end
        DIV_BUSY: begin
          if (r_cnt == '0) begin
            w_state_next = DIV_DONE;
          end else begin
            w_cnt_next = r_cnt - 1'b1;
          end
        end
        DIV_DONE: begin
          w_state_next = DIV_IDLE;
        end
        default: begin
          w_state_next = DIV_IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  assign o_busy = (r_state == DIV_BUSY);
  assign o_done = (r_state == DIV_DONE);
  assign o_idle = (r_state == DIV_IDLE);

endmodule : div_seq_fsm

// File: rtl/issue_ctrl.sv
// Issue controller: register scoreboard with write-through bypass of the
// retiring writeback, issue/stall decision for the IS head, and sequencing
// of the multi-cycle divider.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int DIV_LAT = 33,
  parameter int NREG    = REG_NUM
) (
  input  logic            clk,
  input  logic            reset,      // asynchronous, active-low
  input  logic            flush,
  input  logic            is_valid,
  input  logic [4:0]      is_rj,
  input  logic [4:0]      is_rkd,
  input  logic [4:0]      is_dest,
  input  logic            is_gr_we,
  input  logic            is_div,
  input  logic            es_allowin,
  input  logic            wb_valid,
  input  logic [4:0]      wb_dest,
  input  logic            wb_gr_we,
  output logic            is_issue,
  output logic            is_stall,
  output logic            div_busy,
  output logic            div_done,
  output logic [NREG-1:0] pend_vec
);

  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_next;
  logic [NREG-1:0] w_set;     // issue marks destination pending
  logic [NREG-1:0] w_clr;     // writeback retires destination
  logic [NREG-1:0] w_eff;     // pending after same-cycle writeback bypass
  logic            w_div_idle;
  logic            w_issue;

  // Per-register set/clear decode and next-state; r0 is never tracked
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
      if (gi == 0) begin : g_r0
        assign w_set[gi]       = 1'b0;
        assign w_clr[gi]       = 1'b0;
        assign w_pend_next[gi] = 1'b0;
      end else begin : g_rn
        assign w_set[gi] = w_issue & is_gr_we & (is_dest == 5'(gi));
        assign w_clr[gi] = wb_valid & wb_gr_we & (wb_dest == 5'(gi));
        // flush beats everything; a new set beats a same-cycle retire
        assign w_pend_next[gi] = flush     ? 1'b0 :
                                 w_set[gi] ? 1'b1 :
                                 w_clr[gi] ? 1'b0 : r_pend[gi];
      end
    end
  endgenerate

  assign w_eff = r_pend & ~w_clr;

  // Zero-latency issue decision; held low while reset is asserted
  assign w_issue = reset & is_valid & es_allowin
                 & ~w_eff[is_rj] & ~w_eff[is_rkd]
                 & ~(is_gr_we & w_eff[is_dest])
                 & ~(is_div & ~w_div_idle)
                 & ~flush;

  // Scoreboard register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_next;
    end
  end

  div_seq_fsm #(
    .DIV_LAT (DIV_LAT)
  ) u_div_seq (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_issue & is_div),
    .i_flush (flush),
    .o_busy  (div_busy),
    .o_done  (div_done),
    .o_idle  (w_div_idle)
  );

  assign is_issue = w_issue;
  assign is_stall = reset & is_valid & ~w_issue;
  assign pend_vec = r_pend;

endmodule : issue_ctrl

// File: tb/tb_issue_ctrl.sv
// Testbench for issue_ctrl: table of single-cycle vectors checked through an
// expectation queue, then hand-written divider, flush and reset sequences.
module tb_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        is_valid;
  logic [4:0]  is_rj, is_rkd, is_dest;
  logic        is_gr_we, is_div, es_allowin;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic        wb_gr_we;
  logic        is_issue, is_stall, div_busy, div_done;
  logic [31:0] pend_vec;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  issue_ctrl #(.DIV_LAT(33), .NREG(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .is_valid(is_valid), .is_rj(is_rj), .is_rkd(is_rkd), .is_dest(is_dest),
    .is_gr_we(is_gr_we), .is_div(is_div), .es_allowin(es_allowin),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_gr_we(wb_gr_we),
    .is_issue(is_issue), .is_stall(is_stall),
    .div_busy(div_busy), .div_done(div_done), .pend_vec(pend_vec)
  );

  typedef struct {
    logic       v;
    logic [4:0] rj, rkd, dest;
    logic       we, dv, al, wbv;
    logic [4:0] wbd;
    logic       wbwe, fl;
    logic       ei, es;
    logic [31:0] ep;
  } vec_t;

  typedef struct {
    logic        ei, es;
    logic [31:0] ep;
  } exp_t;

  vec_t tbl[14];
  exp_t q_exp[$];

  function automatic vec_t mk(input logic v, input logic [4:0] rj, input logic [4:0] rkd,
                              input logic [4:0] dest, input logic we, input logic dv,
                              input logic al, input logic wbv, input logic [4:0] wbd,
                              input logic wbwe, input logic fl, input logic ei,
                              input logic es, input logic [31:0] ep);
    vec_t x;
    x.v = v; x.rj = rj; x.rkd = rkd; x.dest = dest; x.we = we; x.dv = dv;
    x.al = al; x.wbv = wbv; x.wbd = wbd; x.wbwe = wbwe; x.fl = fl;
    x.ei = ei; x.es = es; x.ep = ep;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic set_in(input vec_t x);
    is_valid = x.v; is_rj = x.rj; is_rkd = x.rkd; is_dest = x.dest;
    is_gr_we = x.we; is_div = x.dv; es_allowin = x.al;
    wb_valid = x.wbv; wb_dest = x.wbd; wb_gr_we = x.wbwe; flush = x.fl;
  endtask

  task automatic idle_in();
    set_in(mk(0,0,0,0,0,0,1,0,0,0,0,0,0,0));
  endtask

  task automatic cyc_next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    int   n;
    logic done_seen;

    //       v rj rkd dst we dv al wbv wbd wbwe fl  ei es  pend_after
    tbl[0]  = mk(1, 1, 2, 4, 1, 0, 1, 0, 0, 0, 0, 1, 0, 32'h0000_0010); // add r4
    tbl[1]  = mk(1, 4, 0, 5, 1, 0, 1, 0, 0, 0, 0, 0, 1, 32'h0000_0010); // RAW on r4
    tbl[2]  = mk(1, 4, 0, 5, 1, 0, 1, 0, 0, 0, 0, 0, 1, 32'h0000_0010);
    tbl[3]  = mk(1, 4, 0, 5, 1, 0, 1, 1, 4, 1, 0, 1, 0, 32'h0000_0020); // wb r4 bypass
    tbl[4]  = mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 32'h0000_0020); // dest r0
    tbl[5]  = mk(1, 0, 0, 7, 1, 0, 1, 1, 7, 1, 0, 1, 0, 32'h0000_00A0); // set beats clr
    tbl[6]  = mk(1, 1, 2, 8, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_00A0); // backpressure
    tbl[7]  = mk(1, 0, 5, 9, 1, 0, 1, 1, 5, 0, 0, 0, 1, 32'h0000_00A0); // wb w/o gr_we
    tbl[8]  = mk(1, 0, 0, 7, 1, 0, 1, 0, 0, 0, 0, 0, 1, 32'h0000_00A0); // WAW on r7
    tbl[9]  = mk(1, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 1, 0, 32'h0000_00A0); // no write
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 1, 1, 7, 1, 0, 0, 0, 32'h0000_0020); // retire r7
    tbl[11] = mk(1, 0, 0, 9, 1, 0, 1, 0, 0, 0, 1, 0, 1, 32'h0000_0000); // flush
    tbl[12] = mk(1, 9, 0, 9, 1, 0, 1, 0, 0, 0, 0, 1, 0, 32'h0000_0200);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 1, 1, 9, 1, 0, 0, 0, 32'h0000_0000);

    // Reset state, with a ready instruction presented
    reset = 1'b0;
    set_in(mk(1,0,0,3,1,0,1,0,0,0,0,0,0,0));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pend", pend_vec, 32'h0);
    chk("rst_busy", {31'b0, div_busy}, 32'h0);
    chk("rst_done", {31'b0, div_done}, 32'h0);
    chk("rst_issue", {31'b0, is_issue}, 32'h0);
    chk("rst_stall", {31'b0, is_stall}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    idle_in();

    // Table-driven vectors through the expectation queue
    cyc_next();
    for (int i = 0; i < 14; i++) begin
      set_in(tbl[i]);
      q_exp.push_back('{ei: tbl[i].ei, es: tbl[i].es, ep: tbl[i].ep});
      @(negedge clk);
      e = q_exp[0];
      chk($sformatf("vec%0d_issue", i), {31'b0, is_issue}, {31'b0, e.ei});
      chk($sformatf("vec%0d_stall", i), {31'b0, is_stall}, {31'b0, e.es});
      cyc_next();
      e = q_exp.pop_front();
      chk($sformatf("vec%0d_pend", i), pend_vec, e.ep);
    end
    idle_in();

    // Divider latency: first div (dest r3) issues at cycle t
    set_in(mk(1,0,0,3,1,1,1,0,0,0,0,0,0,0));
    @(negedge clk);
    chk("div1_issue", {31'b0, is_issue}, 32'h1);
    cyc_next();
    set_in(mk(1,0,0,0,0,1,1,0,0,0,0,0,0,0));   // second div waiting
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k == 1) chk("div1_pend_r3", pend_vec, 32'h0000_0008);
      if (k == 1 || k == 2 || k == 33) begin
        chk($sformatf("div1_busy_t%0d", k), {31'b0, div_busy}, 32'h1);
        chk($sformatf("div1_done_t%0d", k), {31'b0, div_done}, 32'h0);
        chk($sformatf("div2_held_t%0d", k), {31'b0, is_issue}, 32'h0);
      end else if (!div_busy || div_done || is_issue) begin
        chk($sformatf("div1_busy_window_t%0d", k),
            {29'b0, div_busy, div_done, is_issue}, 32'h4);
      end
      cyc_next();
    end
    @(negedge clk);
    chk("div1_busy_t34", {31'b0, div_busy}, 32'h0);
    chk("div1_done_t34", {31'b0, div_done}, 32'h1);
    chk("div2_held_t34", {31'b0, is_issue}, 32'h0);
    cyc_next();
    // t+35: second div issues, r3 retires the same cycle
    set_in(mk(1,0,0,0,0,1,1,1,3,1,0,0,0,0));
    @(negedge clk);
    chk("div2_issue_t35", {31'b0, is_issue}, 32'h1);
    chk("div1_done_t35", {31'b0, div_done}, 32'h0);
    cyc_next();

    // Non-div instructions issue under a busy divider: r4 then r7
    set_in(mk(1,0,0,4,1,0,1,0,0,0,0,0,0,0));
    cyc_next();
    set_in(mk(1,0,0,7,1,0,1,0,0,0,0,0,0,0));
    cyc_next();
    idle_in();
    chk("flush_pre_pend", pend_vec, 32'h0000_0090);
    chk("flush_pre_busy", {31'b0, div_busy}, 32'h1);
    set_in(mk(1,0,0,9,1,0,1,0,0,0,1,0,0,0));
    @(negedge clk);
    chk("flush_issue", {31'b0, is_issue}, 32'h0);
    cyc_next();
    idle_in();
    chk("flush_pend", pend_vec, 32'h0);
    chk("flush_busy", {31'b0, div_busy}, 32'h0);
    done_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (div_done) done_seen = 1'b1;
    end
    chk("flush_no_done", {31'b0, done_seen}, 32'h0);
    cyc_next();

    // Async reset mid-BUSY
    set_in(mk(1,0,0,6,1,1,1,0,0,0,0,0,0,0));
    cyc_next();
    idle_in();
    repeat (5) cyc_next();
    chk("arst_pre_busy", {31'b0, div_busy}, 32'h1);
    chk("arst_pre_pend", pend_vec, 32'h0000_0040);
    set_in(mk(1,0,0,2,1,0,1,0,0,0,0,0,0,0));
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'b0, div_busy}, 32'h0);
    chk("arst_done", {31'b0, div_done}, 32'h0);
    chk("arst_pend", pend_vec, 32'h0);
    chk("arst_issue", {31'b0, is_issue}, 32'h0);
    chk("arst_stall", {31'b0, is_stall}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    idle_in();
    cyc_next();
    set_in(mk(1,0,0,0,0,1,1,0,0,0,0,0,0,0));
    @(negedge clk);
    chk("arst_div_issue", {31'b0, is_issue}, 32'h1);
    cyc_next();
    idle_in();
    n = 1;
    while (!div_done && n < 60) begin
      cyc_next();
      n++;
    end
    chk("arst_div_latency", n, 32'd34);
    chk("arst_div_busy_at_done", {31'b0, div_busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_issue_ctrl
